// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load data, aligns and
// extends it, and drives the register file write port for one cycle per instruction.
module wb_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_is_load,
  input  logic [2:0]       in_load_type,
  input  logic [1:0]       in_byte_off,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             wren,
  output logic [4:0]       addrC,
  output logic [31:0]      data_in_C,
  output logic             pend_valid,
  output logic [4:0]       pend_addr,
  output logic             align_err,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [2:0]  r_load_type;
  logic [1:0]  r_byte_off;

  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_misaligned;

  logic        w_enter_write;
  logic        w_wr_en;
  logic        w_wr_err;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;

  assign in_ready = (r_state != WAIT_MEM);
  assign w_accept = in_valid & in_ready;

  // Little-endian lane selection from the latched load attributes.
  always_comb begin
    w_byte       = mem_rdata[7:0];
    w_half       = r_byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_data  = mem_rdata;
    w_misaligned = 1'b0;
    case (r_byte_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    case (r_load_type)
      LT_LH: begin
        w_load_data  = {{16{w_half[15]}}, w_half};
        w_misaligned = r_byte_off[0];
      end
      LT_LHU: begin
        w_load_data  = {16'h0000, w_half};
        w_misaligned = r_byte_off[0];
      end
      LT_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU: w_load_data = {24'h000000, w_byte};
      default: begin
        w_load_data  = mem_rdata;
        w_misaligned = (r_byte_off != 2'd0);
      end
    endcase
  end

  // Next state plus the values the write port takes on entering WRITE.
  always_comb begin
    w_next        = r_state;
    w_enter_write = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_err      = 1'b0;
    w_wr_addr     = addrC;
    w_wr_data     = data_in_C;
    case (r_state)
      IDLE, WRITE: begin
        if (w_accept) begin
          if (in_is_load) begin
            w_next = WAIT_MEM;
          end else begin
            w_next        = WRITE;
            w_enter_write = 1'b1;
            w_wr_en       = in_reg_write & (|in_rd);
            w_wr_addr     = in_rd;
            w_wr_data     = in_alu_result;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_next        = WRITE;
          w_enter_write = 1'b1;
          w_wr_en       = r_reg_write & (|r_rd) & ~w_misaligned;
          w_wr_err      = w_misaligned;
          w_wr_addr     = r_rd;
          w_wr_data     = w_load_data;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_load_type <= '0;
      r_byte_off  <= '0;
    end else if (w_accept) begin
      r_rd        <= in_rd;
      r_reg_write <= in_reg_write;
      r_load_type <= in_load_type;
      r_byte_off  <= in_byte_off;
    end
  end

  // Outputs are registered so they line up with the WRITE state cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wren         <= 1'b0;
      align_err    <= 1'b0;
      addrC        <= '0;
      data_in_C    <= '0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      retire_count <= '0;
    end else begin
      wren      <= w_wr_en;
      align_err <= w_wr_err;
      if (w_enter_write) begin
        addrC     <= w_wr_addr;
        data_in_C <= w_wr_data;
        if (!w_wr_err) begin
          retire_count <= retire_count + CNT_ONE;
        end
      end
      pend_valid <= (w_next == WAIT_MEM);
      if (w_next == WAIT_MEM) begin
        pend_addr <= (r_state == WAIT_MEM) ? r_rd : in_rd;
      end else begin
        pend_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: handshake, load alignment, misalignment and reset cases.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic [31:0] in_alu_result;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        wren;
  logic [4:0]  addrC;
  logic [31:0] data_in_C;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        align_err;
  logic [15:0] retire_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  wb_stage #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_is_load    (in_is_load),
    .in_load_type  (in_load_type),
    .in_byte_off   (in_byte_off),
    .in_alu_result (in_alu_result),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .wren          (wren),
    .addrC         (addrC),
    .data_in_C     (data_in_C),
    .pend_valid    (pend_valid),
    .pend_addr     (pend_addr),
    .align_err     (align_err),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid      = 1'b0;
    in_rd         = 5'd0;
    in_reg_write  = 1'b0;
    in_is_load    = 1'b0;
    in_load_type  = 3'b000;
    in_byte_off   = 2'd0;
    in_alu_result = 32'h0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = 1'b1;
    in_is_load    = 1'b0;
    in_alu_result = res;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] off);
    in_valid     = 1'b1;
    in_rd        = rd;
    in_reg_write = 1'b1;
    in_is_load   = 1'b1;
    in_load_type = lt;
    in_byte_off  = off;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (retire_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", retire_count); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", pend_valid); end
  endtask

  task automatic test_nonload_stream();
    logic [4:0]  rds [3];
    logic [31:0] vals [3];
    rds[0] = 5'd8;  rds[1] = 5'd9;  rds[2] = 5'd10;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive_alu(rds[i], vals[i]);
      step();
      checks++; if ({wren, addrC, data_in_C} !== {1'b1, rds[i], vals[i]}) begin
        errors++; $display("FAIL stream_write%0d: got wren=%b addr=%0d data=%h expected 1/%0d/%h",
                           i, wren, addrC, data_in_C, rds[i], vals[i]);
      end
    end
    drive_idle();
    step();
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL stream_idle_wren: got %b expected 0", wren); end
    checks++; if (retire_count !== 16'd3) begin errors++; $display("FAIL stream_count: got %0d expected 3", retire_count); end
  endtask

  task automatic run_byte_load(input logic [2:0] lt, input logic [31:0] exp_data, input string nm);
    drive_load(5'd4, lt, 2'd2);
    step();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({pend_valid, pend_addr, in_ready, wren} !== {1'b1, 5'd4, 1'b0, 1'b0}) begin
        errors++; $display("FAIL %s_wait%0d: got pend=%b addr=%0d ready=%b wren=%b expected 1/4/0/0",
                           nm, i, pend_valid, pend_addr, in_ready, wren);
      end
      if (i < 3) step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12F45678;
    step();
    drive_idle();
    checks++; if ({wren, addrC, data_in_C, pend_valid} !== {1'b1, 5'd4, exp_data, 1'b0}) begin
      errors++; $display("FAIL %s_write: got wren=%b addr=%0d data=%h pend=%b expected 1/4/%h/0",
                         nm, wren, addrC, data_in_C, pend_valid, exp_data);
    end
    step();
  endtask

  task automatic test_byte_loads();
    run_byte_load(3'b011, 32'hFFFFFFF4, "lb");
    run_byte_load(3'b100, 32'h000000F4, "lbu");
    checks++; if (retire_count !== 16'd5) begin errors++; $display("FAIL byte_count: got %0d expected 5", retire_count); end
  endtask

  task automatic test_halfword();
    drive_load(5'd12, 3'b001, 2'd1);
    step();
    drive_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001FFFF;
    step();
    drive_idle();
    checks++; if ({align_err, wren} !== 2'b10) begin
      errors++; $display("FAIL lh_misaligned: got align_err=%b wren=%b expected 1/0", align_err, wren);
    end
    checks++; if (retire_count !== 16'd5) begin errors++; $display("FAIL lh_mis_count: got %0d expected 5", retire_count); end
    step();
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_pulse: got %b expected 0", align_err); end

    drive_load(5'd13, 3'b010, 2'd2);
    step();
    drive_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001FFFF;
    step();
    drive_idle();
    checks++; if ({wren, align_err, addrC, data_in_C} !== {1'b1, 1'b0, 5'd13, 32'h00008001}) begin
      errors++; $display("FAIL lhu_write: got wren=%b err=%b addr=%0d data=%h expected 1/0/13/00008001",
                         wren, align_err, addrC, data_in_C);
    end

    drive_load(5'd14, 3'b001, 2'd2);
    step();
    drive_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001FFFF;
    step();
    drive_idle();
    checks++; if ({wren, data_in_C} !== {1'b1, 32'hFFFF8001}) begin
      errors++; $display("FAIL lh_sign: got wren=%b data=%h expected 1/FFFF8001", wren, data_in_C);
    end

    drive_load(5'd15, 3'b000, 2'd3);
    step();
    drive_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5A5A5;
    step();
    drive_idle();
    checks++; if ({align_err, wren} !== 2'b10) begin
      errors++; $display("FAIL lw_misaligned: got align_err=%b wren=%b expected 1/0", align_err, wren);
    end
    step();
    checks++; if (retire_count !== 16'd7) begin errors++; $display("FAIL half_count: got %0d expected 7", retire_count); end
  endtask

  task automatic test_r0_write();
    drive_alu(5'd0, 32'hDEADBEEF);
    step();
    drive_idle();
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL r0_wren: got %b expected 0", wren); end
    step();
    checks++; if (retire_count !== 16'd8) begin errors++; $display("FAIL r0_count: got %0d expected 8", retire_count); end
  endtask

  task automatic test_back_to_back();
    drive_alu(5'd5, 32'h55);
    step();
    drive_load(5'd6, 3'b000, 2'd0);
    checks++; if ({wren, addrC, data_in_C} !== {1'b1, 5'd5, 32'h55}) begin
      errors++; $display("FAIL b2b_first: got wren=%b addr=%0d data=%h expected 1/5/00000055", wren, addrC, data_in_C);
    end
    step();
    drive_alu(5'd7, 32'h77);
    checks++; if ({in_ready, wren, pend_valid, pend_addr} !== {1'b0, 1'b0, 1'b1, 5'd6}) begin
      errors++; $display("FAIL b2b_wait: got ready=%b wren=%b pend=%b addr=%0d expected 0/0/1/6",
                         in_ready, wren, pend_valid, pend_addr);
    end
    step();
    checks++; if ({in_ready, wren, addrC} !== {1'b0, 1'b0, 5'd5}) begin
      errors++; $display("FAIL b2b_held: got ready=%b wren=%b addr=%0d expected 0/0/5", in_ready, wren, addrC);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    checks++; if ({wren, addrC, data_in_C, in_ready} !== {1'b1, 5'd6, 32'hCAFEF00D, 1'b1}) begin
      errors++; $display("FAIL b2b_load: got wren=%b addr=%0d data=%h ready=%b expected 1/6/CAFEF00D/1",
                         wren, addrC, data_in_C, in_ready);
    end
    step();
    drive_idle();
    checks++; if ({wren, addrC, data_in_C} !== {1'b1, 5'd7, 32'h77}) begin
      errors++; $display("FAIL b2b_held_write: got wren=%b addr=%0d data=%h expected 1/7/00000077", wren, addrC, data_in_C);
    end
    step();
    checks++; if (retire_count !== 16'd11) begin errors++; $display("FAIL b2b_count: got %0d expected 11", retire_count); end
  endtask

  task automatic test_reset_mid_load();
    drive_load(5'd20, 3'b000, 2'd0);
    step();
    drive_idle();
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({pend_valid, pend_addr, retire_count} !== {1'b0, 5'd0, 16'd0}) begin
      errors++; $display("FAIL midreset_async: got pend=%b addr=%0d count=%0d expected 0/0/0",
                         pend_valid, pend_addr, retire_count);
    end
    step();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h01234567;
    step();
    mem_rvalid = 1'b0;
    step();
    checks++; if ({wren, pend_valid, retire_count} !== {1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL midreset_after: got wren=%b pend=%b count=%0d expected 0/0/0",
                         wren, pend_valid, retire_count);
    end
    checks++; if (addrC !== 5'd0) begin errors++; $display("FAIL midreset_addr: got %0d expected 0", addrC); end
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_nonload_stream();
    test_byte_loads();
    test_halfword();
    test_r0_write();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the general-purpose register file.
- Accepts one retiring instruction per handshake from the memory stage and waits for load data when needed.
- Aligns and sign/zero-extends load data, then drives the register file write port (wren, addrC, data_in_C) for exactly one cycle per instruction.
- Also exports the pending and retiring destination to the hazard/forwarding logic.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes a register
- in_is_load  in  1  result comes from memory
- in_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 treated as LW
- in_byte_off  in  2  address[1:0] of the load
- in_alu_result  in  32  result for non-loads
- mem_rdata  in  32  word returned by data memory
- mem_rvalid  in  1  mem_rdata valid this cycle
- wren  out  1  register file write enable
- addrC  out  5  register file write address
- data_in_C  out  32  register file write data
- pend_valid  out  1  load waiting for memory
- pend_addr  out  5  its destination; 0 when pend_valid=0
- align_err  out  1  one-cycle pulse on a misaligned load
- retire_count  out  CNT_W  instructions retired without error

Behaviour:
- Reset:
  - rst=0 asynchronously forces state IDLE.
  - Clears wren, addrC, data_in_C, pend_valid, pend_addr, align_err, retire_count and all latched fields.
  - Takes effect mid-operation; a pending load is dropped.
  - A mem_rvalid arriving after reset in IDLE is ignored.
- States:
  - IDLE: no instruction.
  - WAIT_MEM: load accepted, awaiting mem_rvalid.
  - WRITE: result registered; wren/align_err are valid this cycle.
- in_ready = (state != WAIT_MEM), combinational. Accept = in_valid & in_ready at a rising edge.
- Accept transitions (from IDLE or WRITE):
  - Non-load -> WRITE, with result = in_alu_result.
  - Load -> WAIT_MEM, latching rd, reg_write, load_type and byte_off.
- No accept: WRITE -> IDLE; IDLE stays IDLE.
- WAIT_MEM:
  - mem_rvalid is sampled only in this state, so the earliest sample is the cycle after accept.
  - On mem_rvalid=1: capture the aligned result and go to WRITE.
  - Otherwise hold indefinitely.
- Latency and throughput:
  - Non-load: wren asserted the cycle after accept; back-to-back non-loads give one write per cycle.
  - Load: wren asserted the cycle after mem_rvalid.
- Outputs (registered):
  - In WRITE: wren = reg_write & (rd != 0) & ~misaligned; addrC = rd; data_in_C = result.
  - Outside WRITE: wren = 0; addrC and data_in_C hold their last values.
  - Writes to r0 are never issued, but still count as retired.
- Load alignment, little-endian (byte k = mem_rdata[8k+7:8k]):
  - LB/LBU: byte at byte_off, sign- or zero-extended.
  - LH/LHU: half mem_rdata[31:16] if byte_off[1], else [15:0], sign- or zero-extended.
  - LW: full word.
- Misalignment:
  - Misaligned cases: LH/LHU with byte_off[0]=1; LW with byte_off != 0.
  - In WRITE: align_err=1, wren=0, retire_count unchanged.
- Pending status: pend_valid=1 and pend_addr=rd throughout WAIT_MEM, including the cycle mem_rvalid arrives. pend_valid=0 in all other states.
- retire_count increments by 1 in every WRITE cycle without align_err, and wraps from all-ones to 0.
- Simultaneous events:
  - Accept in WRITE: the current write completes this cycle and the new instruction is captured at the same edge.
  - in_valid during WAIT_MEM: not accepted; the upstream holds it.

Test Plan:
1. Reset then idle: rst low for 2 cycles, release -> wren=0, in_ready=1, retire_count=0, pend_valid=0.
2. Three back-to-back non-loads (rd=8,9,10; alu=0x11,0x22,0x33) -> wren high 3 consecutive cycles, each one cycle after its accept, with the matching addrC/data_in_C; retire_count=3.
3. LB rd=4, byte_off=2, mem_rvalid after 3 wait cycles with mem_rdata=0x12F45678 -> pend_valid=1, pend_addr=4 and in_ready=0 for the wait cycles; next cycle wren=1, addrC=4, data_in_C=0xFFFFFFF4. Repeat as LBU -> 0x000000F4.
4. LH byte_off=1 -> align_err pulse, wren=0, retire_count unchanged. LHU byte_off=2 on mem_rdata=0x8001FFFF -> data_in_C=0x00008001.
5. Non-load with rd=0, alu=0xDEADBEEF -> wren stays 0, retire_count increments.
6. rst pulled low during WAIT_MEM, then mem_rvalid asserted after release -> no write, pend_valid=0, retire_count=0.
